// File: rtl/postfix_pkg.sv
// postfix_pkg: shared constants, FSM state type and operator ranking for the
// infix-to-postfix sequencer.
//
// Configuration macro: POSTFIX_PREC_EN
//   undefined : every operator has the same rank and all are left-associative
//   defined   : '*' ranks above '+' and '-'
package postfix_pkg;

    localparam logic [7:0] NUL    = 8'd0;
    localparam logic [7:0] LPAREN = 8'd40;
    localparam logic [7:0] RPAREN = 8'd41;
    localparam logic [7:0] OP_MUL = 8'd42;
    localparam logic [7:0] OP_ADD = 8'd43;
    localparam logic [7:0] OP_SUB = 8'd45;

    typedef enum logic [2:0] {
        ACCEPT,
        POP_OP,
        POP_PAREN,
        FLUSH,
        TERM,
        ERROR
    } state_e;

    // Rank 0 marks a non-operator, so callers can use it as an is-operator test.
    function automatic logic [1:0] op_prec(input logic [7:0] c);
`ifdef POSTFIX_PREC_EN
        if (c == OP_MUL) return 2'd2;
        if ((c == OP_ADD) || (c == OP_SUB)) return 2'd1;
        return 2'd0;
`else
        return ((c == OP_MUL) || (c == OP_ADD) || (c == OP_SUB)) ? 2'd1 : 2'd0;
`endif
    endfunction

endpackage

// File: rtl/postfix_seq_ctrl_op_stack.sv
// postfix_op_stack: LIFO holding pending operators and '(' markers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the stack)
//   push, push_char   write push_char on top (ignored when full)
//   pop               drop the top entry (ignored when empty)
//   top               current top entry (meaningless when empty)
//   empty, full       occupancy flags
module postfix_op_stack #(
    parameter int STACK_DEPTH = 16,
    parameter int CHAR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [CHAR_W-1:0] push_char,
    output logic [CHAR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0] SP_ONE = (AW+1)'(1);

    logic [AW:0]       sp_q, sp_d;
    logic [CHAR_W-1:0] mem_q [STACK_DEPTH];
    logic [AW-1:0]     top_idx;

    // Depth is a power of two, so the extra pointer bit alone means full.
    assign empty   = (sp_q == '0);
    assign full    = sp_q[AW];
    assign top_idx = AW'(sp_q - SP_ONE);
    assign top     = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_ONE;
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[AW-1:0]] <= push_char;
        end
    end

endmodule

// File: rtl/postfix_seq_ctrl.sv
// postfix_seq_ctrl: streaming shunting-yard converter, infix characters in,
// postfix characters out, one character per handshake.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid, in_ready, in_char    infix input stream (8'd0 ends an expression)
//   out_valid, out_ready, out_char postfix output stream from one holding register
//   out_last                       marks the 8'd0 terminator beat
//   busy                           expression in progress
//   err                            sticky syntax / stack-overflow error
//
// Configuration macro: POSTFIX_PREC_EN (operator precedence, see postfix_pkg).
//
// state     | meaning
// ----------+----------------------------------------------------------
// ACCEPT    | take one input character per loadable cycle
// POP_OP    | pop higher-or-equal operators, then push the latched one
// POP_PAREN | pop operators down to the matching '(' and discard it
// FLUSH     | end of input: pop every remaining operator
// TERM      | emit the 8'd0 terminator with out_last
// ERROR     | sticky error; only rst leaves this state
module postfix_seq_ctrl
    import postfix_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int CHAR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic [CHAR_W-1:0] op_q, op_d;
    logic              out_valid_q, out_valid_d;
    logic [CHAR_W-1:0] out_char_q, out_char_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              load_ok;
    logic              push, pop;
    logic [CHAR_W-1:0] push_char, top;
    logic              empty, full;

    // Characters wider than 8 bits with upper bits set are always operands.
    function automatic logic [1:0] prec_of(input logic [CHAR_W-1:0] c);
        return (c == CHAR_W'(c[7:0])) ? op_prec(c[7:0]) : 2'd0;
    endfunction

    postfix_op_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .CHAR_W     (CHAR_W)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_char(push_char),
        .top      (top),
        .empty    (empty),
        .full     (full)
    );

    assign load_ok   = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ACCEPT) && load_ok;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        err_d       = err_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q && !out_ready;
        out_char_d  = out_char_q;
        out_last_d  = out_last_q;
        push        = 1'b0;
        pop         = 1'b0;
        push_char   = in_char;

        if (out_valid_q && out_ready && out_last_q) begin
            busy_d = 1'b0;
        end

        // Nothing advances unless the holding register can take a beat.
        if (load_ok) begin
            unique case (state_q)
                ACCEPT: begin
                    if (in_valid) begin
                        busy_d = 1'b1;
                        if (in_char == CHAR_W'(NUL)) begin
                            state_d = FLUSH;
                        end else if (in_char == CHAR_W'(LPAREN)) begin
                            if (full) begin
                                state_d = ERROR;
                                err_d   = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
                        end else if (in_char == CHAR_W'(RPAREN)) begin
                            state_d = POP_PAREN;
                        end else if (prec_of(in_char) != 2'd0) begin
                            op_d    = in_char;
                            state_d = POP_OP;
                        end else begin
                            out_valid_d = 1'b1;
                            out_char_d  = in_char;
                            out_last_d  = 1'b0;
                        end
                    end
                end
                POP_OP: begin
                    if (!empty && (prec_of(top) != 2'd0) &&
                        (prec_of(top) >= prec_of(op_q))) begin
                        pop         = 1'b1;
                        out_valid_d = 1'b1;
                        out_char_d  = top;
                        out_last_d  = 1'b0;
                    end else if (full) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_char = op_q;
                        state_d   = ACCEPT;
                    end
                end
                POP_PAREN: begin
                    if (empty) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (top == CHAR_W'(LPAREN)) begin
                        pop     = 1'b1;
                        state_d = ACCEPT;
                    end else begin
                        pop         = 1'b1;
                        out_valid_d = 1'b1;
                        out_char_d  = top;
                        out_last_d  = 1'b0;
                    end
                end
                FLUSH: begin
                    if (empty) begin
                        state_d = TERM;
                    end else if (top == CHAR_W'(LPAREN)) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        out_valid_d = 1'b1;
                        out_char_d  = top;
                        out_last_d  = 1'b0;
                    end
                end
                TERM: begin
                    out_valid_d = 1'b1;
                    out_char_d  = CHAR_W'(NUL);
                    out_last_d  = 1'b1;
                    state_d     = ACCEPT;
                end
                ERROR: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCEPT;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/postfix_seq_ctrl.md
POSTFIX_SEQ_CTRL -- requirements
Module: postfix_seq_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, operator-stack entries (power of 2, min 4).
REQ-002 SHALL have parameter CHAR_W, default 8, character width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  infix character offered.
REQ-006 SHALL have port in_ready  output  1  controller accepts in_char this cycle.
REQ-007 SHALL have port in_char  input  CHAR_W  infix character; 8'd0 terminates the expression.
REQ-008 SHALL have port out_valid  output  1  postfix character available.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_char this cycle.
REQ-010 SHALL have port out_char  output  CHAR_W  postfix character.
REQ-011 SHALL have port out_last  output  1  high with the 8'd0 terminator beat.
REQ-012 SHALL have port busy  output  1  expression in progress (first char accepted through terminator handed off).
REQ-013 SHALL have port err  output  1  sticky syntax/overflow error.

Function
REQ-014 SHALL perform shunting-yard conversion one character per accept; '(' = 8'd40, ')' = 8'd41, operators '*' 8'd42, '+' 8'd43, '-' 8'd45; all other nonzero codes are operands.
REQ-015 SHALL register outputs: one output holding register, loadable when !out_valid || out_ready; out_char/out_last stable while out_valid && !out_ready.
REQ-016 SHALL use FSM states ACCEPT, POP_OP, POP_PAREN, FLUSH, TERM, ERROR.
REQ-017 ACCEPT: in_ready = 1 only when the holding register is loadable; accepted operand appears on out_char with out_valid in the next cycle (latency 1).
REQ-018 ACCEPT, '(' accepted: push; stay ACCEPT; no output.
REQ-019 ACCEPT, operator accepted: latch it, go POP_OP; POP_OP pops one stack entry to the output per loadable cycle while top is a poppable operator (REQ-033), then pushes the latched operator in the cycle the pop condition fails, returning to ACCEPT.
REQ-020 ACCEPT, ')' accepted: go POP_PAREN; pops one operator per loadable cycle; on top == '(' discards it (no output) and returns to ACCEPT; stack empty in POP_PAREN -> ERROR.
REQ-021 ACCEPT, 8'd0 accepted: go FLUSH; pops one operator per loadable cycle; top == '(' -> ERROR; stack empty -> TERM.
REQ-022 TERM: loads 8'd0 with out_last = 1; on load goes ACCEPT with stack empty, busy deasserts after out_ready handshake of that beat.
REQ-023 in_ready SHALL be 0 in every state except ACCEPT.
REQ-024 Push with stack full SHALL go ERROR; nothing is pushed.
REQ-025 ERROR: err = 1, in_ready = 0, any pending out_valid beat still drains, no new outputs; exit only by rst.
REQ-026 Empty expression (first char 8'd0) SHALL produce a single 8'd0 beat with out_last = 1.
REQ-027 Stall: while holding register not loadable, no pop, push or state change occurs.

Reset
REQ-028 On rst: state ACCEPT, stack pointer 0, out_valid 0, out_char 0, out_last 0, busy 0, err 0.
REQ-029 rst mid-expression SHALL abandon it; no terminator emitted; next accepted character starts a new expression.
REQ-030 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-031 Macro POSTFIX_PREC_EN selects operator precedence.
REQ-032 Without POSTFIX_PREC_EN: all operators equal, left-associative; POP_OP pops every entry above the nearest '('.
REQ-033 With POSTFIX_PREC_EN: '*' ranks above '+','-'; POP_OP pops while top is an operator of precedence >= the latched operator.

Structure
REQ-034 Package postfix_pkg SHALL hold the character constants (LPAREN, RPAREN, OP_MUL, OP_ADD, OP_SUB, NUL), the FSM state enum and the precedence function.
REQ-035 Sub-module postfix_op_stack (parameter STACK_DEPTH, CHAR_W; push, pop, top, empty, full) SHALL hold the LIFO; all sequencing stays in postfix_seq_ctrl.

Verification
REQ-036 "A+B",0 with out_ready = 1 -> out "A","B","+",0 (last on 0); err = 0.
REQ-037 "(A+B)*C",0 -> "A","B","+","C","*",0.
REQ-038 "A+B*C",0 -> "AB+C*",0 without POSTFIX_PREC_EN; "ABC*+",0 with it.
REQ-039 "A+B",0 with out_ready toggling 1/0 each cycle -> same sequence, out_char stable across every stalled cycle, no beat lost or duplicated.
REQ-040 "A)",0 -> "A" emitted, err = 1 after ')', in_ready stays 0 until rst; after rst "B",0 -> "B",0.
REQ-041 STACK_DEPTH = 4, "(((((" -> err = 1 on fifth '('; 8'd0 alone after rst -> single 0 beat with out_last = 1.
